// File: rtl/tt_mask_idx_rx.sv
// Receive end of the vector mask/index credit link: buffers pushed items in a
// credit-sized FIFO and serves them as a per-element {active, index} stream.
module tt_mask_idx_rx #(
   parameter int VLEN         = 256,
   parameter int MASK_CREDITS = 2
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      i_mask_idx_valid,
   input  logic [64:0]               i_mask_idx_item,
   input  logic                      i_mask_idx_last_idx,
   output logic                      o_mask_idx_credit,
   input  logic                      i_start,
   input  logic                      i_is_indexed,
   input  logic [$clog2(VLEN+1)-1:0] i_vl,
   output logic                      o_elem_valid,
   input  logic                      i_elem_ready,
   output logic                      o_elem_active,
   output logic [63:0]               o_elem_index,
   output logic                      o_elem_last,
   output logic                      o_busy,
   output logic                      o_err
);
   localparam int VL_W  = $clog2(VLEN + 1);
   localparam int PTR_W = (MASK_CREDITS > 1) ? $clog2(MASK_CREDITS) : 1;
   localparam int CNT_W = $clog2(MASK_CREDITS + 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   state_t state_q, state_d;

   logic [65:0]      fifo_mem [MASK_CREDITS];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] fifo_cnt_q;
   logic             fifo_empty, fifo_full;
   logic             push, pop, xfer, ends_memop;
   logic [65:0]      head;
   logic [63:0]      head_bits;

   logic             mode_q;
   logic [VL_W-1:0]  vl_q, elem_cnt_q;
   logic [5:0]       offset;
   logic             is_last;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MASK_CREDITS - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign fifo_empty = (fifo_cnt_q == '0);
   assign fifo_full  = (fifo_cnt_q == CNT_W'(MASK_CREDITS));
   // A full FIFO still accepts a push in the same cycle its head is popped.
   assign push       = i_mask_idx_valid && (!fifo_full || pop);
   assign head       = fifo_mem[rd_ptr_q];
   assign head_bits  = head[63:0];
   assign offset     = elem_cnt_q[5:0];
   assign is_last    = (elem_cnt_q == vl_q - VL_W'(1));
   assign o_busy     = (state_q != IDLE);

   // NOTE: the storage array has no reset; the reset pointers and count define occupancy.
   always_ff @(posedge i_clk) begin
      if (push) fifo_mem[wr_ptr_q] <= {i_mask_idx_last_idx, i_mask_idx_item};
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q           <= IDLE;
         wr_ptr_q          <= '0;
         rd_ptr_q          <= '0;
         fifo_cnt_q        <= '0;
         o_mask_idx_credit <= 1'b0;
         o_err             <= 1'b0;
         mode_q            <= 1'b0;
         vl_q              <= '0;
         elem_cnt_q        <= '0;
      end else begin
         state_q           <= state_d;
         o_mask_idx_credit <= pop;
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
         else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
         // Sticky: dropped push, or an entry whose last flag disagrees with the pop.
         if ((i_mask_idx_valid && !push) || (pop && (head[65] != ends_memop)))
            o_err <= 1'b1;
         if (state_q == IDLE && i_start) begin
            mode_q     <= i_is_indexed;
            vl_q       <= i_vl;
            elem_cnt_q <= '0;
         end else if (xfer) begin
            elem_cnt_q <= elem_cnt_q + VL_W'(1);
         end
      end
   end

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      o_elem_valid  = 1'b0;
      o_elem_active = 1'b0;
      o_elem_index  = '0;
      o_elem_last   = 1'b0;
      xfer          = 1'b0;
      pop           = 1'b0;
      ends_memop    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               if (i_vl != '0)         state_d = RUN;
               else if (!i_is_indexed) state_d = FLUSH;
            end
         end
         RUN: begin
            o_elem_valid = !fifo_empty;
            o_elem_last  = is_last;
            xfer         = !fifo_empty && i_elem_ready;
            ends_memop   = is_last;
            if (mode_q) begin
               o_elem_active = head[64];
               o_elem_index  = head_bits;
               pop           = xfer;
            end else begin
               o_elem_active = head_bits[offset];
               pop           = xfer && ((offset == 6'd63) || is_last);
            end
            if (xfer && is_last) state_d = IDLE;
         end
         FLUSH: begin
            // A zero-length mask memop still carries one item from the sender.
            if (!fifo_empty) begin
               pop        = 1'b1;
               ends_memop = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_tt_mask_idx_rx.sv
// Self-checking bench for tt_mask_idx_rx: credit-driven sender, element-level
// reference model, directed protocol/error/reset cases plus randomized memops.
module tb_tt_mask_idx_rx;
   localparam int VLEN = 256;
   localparam int MC   = 2;
   localparam int VL_W = $clog2(VLEN + 1);

   logic            clk = 1'b0;
   logic            rst_n;
   logic            mi_valid, mi_last, credit, start, is_idx;
   logic [64:0]     mi_item;
   logic [VL_W-1:0] vl_s;
   logic            e_valid, e_ready, e_active, e_last, busy, err;
   logic [63:0]     e_index;

   logic [64:0] items_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   tt_mask_idx_rx #(.VLEN(VLEN), .MASK_CREDITS(MC)) dut (
      .i_clk               (clk),
      .i_reset_n           (rst_n),
      .i_mask_idx_valid    (mi_valid),
      .i_mask_idx_item     (mi_item),
      .i_mask_idx_last_idx (mi_last),
      .o_mask_idx_credit   (credit),
      .i_start             (start),
      .i_is_indexed        (is_idx),
      .i_vl                (vl_s),
      .o_elem_valid        (e_valid),
      .i_elem_ready        (e_ready),
      .o_elem_active       (e_active),
      .o_elem_index        (e_index),
      .o_elem_last         (e_last),
      .o_busy              (busy),
      .o_err               (err)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mi_valid = 1'b0; mi_item = '0; mi_last = 1'b0;
      start = 1'b0; is_idx = 1'b0; vl_s = '0; e_ready = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle_inputs();
      #1;
      chk("rst_busy",   64'(busy),    64'd0);
      chk("rst_valid",  64'(e_valid), 64'd0);
      chk("rst_credit", 64'(credit),  64'd0);
      chk("rst_err",    64'(err),     64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Builds the sender's item list for a memop with random contents.
   task automatic fill_random(input bit idx, input int vl);
      int n;
      items_q.delete();
      n = idx ? vl : ((vl == 0) ? 1 : (vl + 63) / 64);
      for (int i = 0; i < n; i++) items_q.push_back({1'($urandom), $urandom, $urandom});
   endtask

   // Runs one memop with a credit-limited sender; every cycle the DUT is
   // compared with the element sequence the items and vl imply.
   // rmode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready.
   task automatic run_memop(input bit idx, input int vl, input int rmode);
      int nitems, sent, received, popped, e, credits, cyc, st, st_nxt;
      bit pop_prev, pop_now, push_now, exp_valid, exp_act, exp_last;
      logic [63:0] exp_idx, bits;
      logic [64:0] it;
      logic [5:0]  off;
      nitems = items_q.size();
      sent = 0; received = 0; popped = 0; e = 0; credits = MC; cyc = 0; st = 0;
      pop_prev = 1'b0;
      while (cyc == 0 || st != 0 || pop_prev) begin
         if (cyc >= 3000) begin
            chk("memop_timeout_state", 64'(st), 64'd0);
            break;
         end
         credits += int'(pop_prev);
         push_now = (sent < nitems) && (credits > 0);
         start    = (cyc == 0);
         is_idx   = idx;
         vl_s     = VL_W'(vl);
         mi_valid = push_now;
         mi_item  = '0;
         mi_last  = 1'b0;
         if (push_now) begin
            mi_item = items_q[sent];
            mi_last = (sent == nitems - 1);
         end
         case (rmode)
            0:       e_ready = 1'b1;
            1:       e_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: e_ready = 1'($urandom);
         endcase

         chk("busy",   64'(busy),   64'(st != 0));
         chk("credit", 64'(credit), 64'(pop_prev));
         exp_valid = (st == 1) && (received > popped);
         chk("elem_valid", 64'(e_valid), 64'(exp_valid));
         if (st != 1) begin
            chk("idle_active", 64'(e_active), 64'd0);
            chk("idle_index",  e_index,       64'd0);
            chk("idle_last",   64'(e_last),   64'd0);
         end else if (exp_valid) begin
            if (idx) begin
               it      = items_q[e];
               exp_act = it[64];
               exp_idx = it[63:0];
            end else begin
               it      = items_q[e / 64];
               bits    = it[63:0];
               off     = 6'(e % 64);
               exp_act = bits[off];
               exp_idx = 64'd0;
            end
            exp_last = (e == vl - 1);
            chk("elem_active", 64'(e_active), 64'(exp_act));
            chk("elem_index",  e_index,       exp_idx);
            chk("elem_last",   64'(e_last),   64'(exp_last));
         end

         st_nxt  = st;
         pop_now = 1'b0;
         if (st == 1) begin
            if (exp_valid && e_ready) begin
               pop_now = idx || (e % 64 == 63) || (e == vl - 1);
               if (e == vl - 1) st_nxt = 0;
               e++;
            end
         end else if (st == 2) begin
            if (received > popped) begin
               pop_now = 1'b1;
               st_nxt  = 0;
            end
         end else if (cyc == 0) begin
            st_nxt = (vl > 0) ? 1 : (idx ? 0 : 2);
         end

         step();
         st        = st_nxt;
         received += int'(push_now);
         sent     += int'(push_now);
         credits  -= int'(push_now);
         popped   += int'(pop_now);
         pop_prev  = pop_now;
         cyc++;
      end
      idle_inputs();
      chk("memop_err", 64'(err), 64'd0);
   endtask

   initial begin
      bit r_idx;
      int r_vl;
      apply_reset();
      step();

      // Mask mode vl=100: A = F0F0... then B, ready held high.
      items_q.delete();
      items_q.push_back({1'b0, 64'hF0F0_F0F0_F0F0_F0F0});
      items_q.push_back({1'b0, $urandom, $urandom});
      run_memop(1'b0, 100, 0);

      // Indexed vl=5: indices 3,7,1,0,9 with active bits 1,0,1,1,0.
      items_q.delete();
      items_q.push_back({1'b1, 64'd3});
      items_q.push_back({1'b0, 64'd7});
      items_q.push_back({1'b1, 64'd1});
      items_q.push_back({1'b1, 64'd0});
      items_q.push_back({1'b0, 64'd9});
      run_memop(1'b1, 5, 0);

      // Backpressure with ready toggling 1,0,0,1.
      fill_random(1'b1, 4);
      run_memop(1'b1, 4, 1);

      // Zero-length memops: mask flushes one item, indexed stays idle.
      fill_random(1'b0, 0);
      run_memop(1'b0, 0, 0);
      fill_random(1'b1, 0);
      run_memop(1'b1, 0, 0);

      // Boundary vl values around 64-bit item edges.
      fill_random(1'b0, 64);
      run_memop(1'b0, 64, 2);
      fill_random(1'b0, 65);
      run_memop(1'b0, 65, 2);
      fill_random(1'b0, 256);
      run_memop(1'b0, 256, 2);

      for (int k = 0; k < 14; k++) begin
         r_idx = 1'($urandom);
         case ($urandom_range(0, 5))
            0:       r_vl = 0;
            1:       r_vl = 1;
            2:       r_vl = 63 + int'($urandom_range(0, 2));
            3:       r_vl = 256;
            default: r_vl = int'($urandom_range(1, 256));
         endcase
         fill_random(r_idx, r_vl);
         run_memop(r_idx, r_vl, 2);
      end

      // Overflow: third push with no pops is dropped and flags the error.
      apply_reset();
      is_idx  = 1'b1;
      e_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mi_valid = 1'b1;
         mi_item  = {1'b1, 64'(k + 10)};
         mi_last  = (k == 1);
         if (k > 0) chk("ovf_err_before", 64'(err), 64'd0);
         step();
      end
      mi_valid = 1'b0; mi_last = 1'b0;
      chk("ovf_err_set", 64'(err), 64'd1);
      start = 1'b1; vl_s = VL_W'(2); e_ready = 1'b1;
      step();
      start = 1'b0;
      chk("ovf_valid0", 64'(e_valid), 64'd1);
      chk("ovf_elem0",  e_index,      64'd10);
      step();
      chk("ovf_elem1",  e_index,      64'd11);
      chk("ovf_last1",  64'(e_last),  64'd1);
      step();
      chk("ovf_dropped",    64'(e_valid), 64'd0);
      chk("ovf_idle",       64'(busy),    64'd0);
      chk("ovf_err_sticky", 64'(err),     64'd1);

      // Protocol: first of two indexed items wrongly flagged last.
      apply_reset();
      is_idx = 1'b1; vl_s = VL_W'(2); start = 1'b1; e_ready = 1'b0;
      mi_valid = 1'b1; mi_item = {1'b0, 64'd5}; mi_last = 1'b1;
      step();
      start = 1'b0; mi_item = {1'b1, 64'd6}; mi_last = 1'b0; e_ready = 1'b1;
      chk("proto_err_before", 64'(err),     64'd0);
      chk("proto_valid",      64'(e_valid), 64'd1);
      step();
      mi_valid = 1'b0;
      chk("proto_err_set", 64'(err), 64'd1);
      step();
      step();

      // Reset after 2 of 4 indexed elements.
      apply_reset();
      is_idx = 1'b1; vl_s = VL_W'(4); start = 1'b1; e_ready = 1'b1;
      mi_valid = 1'b1; mi_item = {1'b1, 64'd100}; mi_last = 1'b0;
      step();
      start = 1'b0; mi_item = {1'b0, 64'd101};
      chk("mid_e0", e_index, 64'd100);
      step();
      mi_valid = 1'b0;
      chk("mid_e1", e_index, 64'd101);
      step();
      chk("mid_credit_pre", 64'(credit), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy",   64'(busy),     64'd0);
      chk("mid_rst_valid",  64'(e_valid),  64'd0);
      chk("mid_rst_active", 64'(e_active), 64'd0);
      chk("mid_rst_index",  e_index,       64'd0);
      chk("mid_rst_last",   64'(e_last),   64'd0);
      chk("mid_rst_credit", 64'(credit),   64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         chk("post_rst_credit", 64'(credit),  64'd0);
         chk("post_rst_valid",  64'(e_valid), 64'd0);
         chk("post_rst_busy",   64'(busy),    64'd0);
         step();
      end
      is_idx = 1'b1; vl_s = VL_W'(1); start = 1'b1;
      step();
      start = 1'b0;
      chk("post_rst_fifo_empty", 64'(e_valid), 64'd0);
      chk("post_rst_run",        64'(busy),    64'd1);
      mi_valid = 1'b1; mi_item = {1'b1, 64'hABC}; mi_last = 1'b1; e_ready = 1'b1;
      step();
      mi_valid = 1'b0; mi_last = 1'b0;
      chk("post_rst_new_item", e_index, 64'hABC);
      step();
      chk("post_rst_credit_new", 64'(credit), 64'd1);
      chk("post_rst_done",       64'(busy),   64'd0);
      chk("post_rst_err",        64'(err),    64'd0);
      idle_inputs();
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/tt_mask_idx_rx.md
# tt_mask_idx_rx

Receive end of the vector mask/index credit interface. This block sits on the memory-pipe side of the VPU and accepts 65-bit mask/index items pushed by the vector unit's mask FSM. It buffers the items in a credit-sized FIFO and returns one credit per freed entry. It then serves the items to the load/store address generator as a per-element stream of {active bit, index}.

## Interface
- VLEN, 256, vector length in bits; sizes `i_vl`.
- MASK_CREDITS, 2, FIFO depth; must equal the sender's initial credit count.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_mask_idx_valid  in  1  item push strobe; there is no ready signal because flow control is by credit.
- i_mask_idx_item  in  65  [64] mask bit for indexed ops; [63:0] is either 64 mask bits (strided/unit ops) or the zero-extended index (indexed ops).
- i_mask_idx_last_idx  in  1  marks the final item of the current memop.
- o_mask_idx_credit  out  1  one-cycle pulse; each pulse returns one credit.
- i_start  in  1  memop start pulse; sampled only in IDLE.
- i_is_indexed  in  1  mode for the memop; sampled with `i_start`.
- i_vl  in  $clog2(VLEN+1)  element count for the memop; sampled with `i_start`.
- o_elem_valid  out  1  an element is presented.
- i_elem_ready  in  1  the consumer accepts the element.
- o_elem_active  out  1  the element's mask bit.
- o_elem_index  out  64  the element's index; 0 in mask mode.
- o_elem_last  out  1  the presented element is element vl-1.
- o_busy  out  1  state is not IDLE.
- o_err  out  1  sticky error flag; cleared only by reset.

## Operation
**FIFO**
- MASK_CREDITS entries, each 66 bits: {last_idx, item}.
- An entry is written whenever `i_mask_idx_valid` is high, in any state.
- A push while the FIFO is full sets `o_err` and the item is dropped.
- A push and a pop may occur in the same cycle, including when the FIFO is full.

**Registers**
- mode (indexed), vl, and elem_cnt (width $clog2(VLEN+1)).

**States: IDLE, RUN, FLUSH**
- IDLE:
  - On `i_start`, latch mode and vl and clear elem_cnt.
  - If vl>0, go to RUN.
  - If vl==0 in mask mode, go to FLUSH, because the sender still emits one item.
  - If vl==0 in indexed mode, stay in IDLE.
- RUN:
  - `o_elem_valid` = FIFO not empty.
  - An element transfers when `o_elem_valid` and `i_elem_ready` are both high.
  - Each transfer increments elem_cnt.
- RUN, mask mode:
  - offset = elem_cnt[5:0].
  - `o_elem_active` = head[offset]; `o_elem_index` = 0.
  - The head is popped on the transfer where offset==63 or the element is the last.
- RUN, indexed mode:
  - `o_elem_active` = head[64]; `o_elem_index` = head[63:0].
  - The head is popped on every transfer.
- RUN, common:
  - `o_elem_last` = (elem_cnt == vl-1).
  - The transfer of the last element returns the state to IDLE.
- FLUSH: when the FIFO is non-empty, pop the head without presenting an element and go to IDLE.

**Protocol check (sets `o_err`)**
- A popped entry's last_idx must equal "this pop ends the memop". A mismatch in either direction sets `o_err`.

**Other rules**
- `i_start` outside IDLE is ignored.
- Outside RUN, `o_elem_valid`, `o_elem_active`, `o_elem_index` and `o_elem_last` are all 0.

## Timing
- Reset values (asynchronous): state IDLE, FIFO empty, all counters 0, all outputs 0.
- No bypass path. An item pushed in cycle N is visible at the head, with `o_elem_valid` high, in cycle N+1 at the earliest.
- Element outputs are combinational from the head entry, elem_cnt and state.
- Credit return: a pop in cycle N gives `o_mask_idx_credit`=1 in cycle N+1, exactly one cycle wide per pop. Back-to-back pops give back-to-back pulses.
- Sustained throughput is one element per cycle. With MASK_CREDITS=2 and a sender round trip of 2 cycles or less, indexed mode runs without bubbles.
- A reset asserted mid-memop discards the FIFO contents. No credit pulses are emitted for discarded entries; the sender is reset in the same domain.

## Test plan
- Mask mode, vl=100: push items A=0x…F0F0 (last=0) and B (last=1), start, ready held at 1. Expect:
  - 100 elements, with elements 0..63 matching A's bits and 64..99 matching B[35:0].
  - Credit pulses in the cycles after elem 63 and after elem 99.
  - `o_elem_last` only on elem 99; `o_err`=0.
- Indexed mode, vl=5, eew-irrelevant indices 3,7,1,0,9 with mask bits 1,0,1,1,0 and the last item flagged. Expect:
  - Indices and active bits in order.
  - 5 credit pulses, return to IDLE after elem 4.
- Backpressure: indexed vl=4 with `i_elem_ready` toggling 1,0,0,1… Expect outputs stable while not ready, no lost or duplicated elements, and credits only on transfers.
- Mask mode vl=0: start, then one item with last=1. Expect FLUSH pops it, one credit pulse, no `o_elem_valid`, back to IDLE.
- Errors:
  - Push 3 items with MASK_CREDITS=2 and no pops: the third is dropped and `o_err`=1.
  - Separately, indexed vl=2 with the first item flagged last: `o_err`=1 on the first pop.
- Reset mid-run: assert `i_reset_n`=0 after 2 of 4 elements. Expect all outputs 0 immediately, FIFO empty, and no credit pulse afterwards.
